mem_responder: RTL and testbench

- Memory-side responder for the CPU RAM interface: services single-cycle read and write enables from the control unit, with zero wait states.
- Holds the main word-addressed RAM array and a small memory-mapped I/O page: LED register, prescaled timer with compare, sticky status, and interrupt output.
- Sits between the control unit and board pins; the CPU's address, write-data, read-enable and write-enable outputs connect directly to it.

---
 rtl/mem_map_pkg.sv | 62 ++++++
 rtl/io_timer.sv | 58 +++++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - shared memory map: I/O page base, register offsets, status/ctrl fields
// Contents:
//   IO_BASE          default base of the 256-word I/O page
//   OFF_*            register offsets within the I/O page
//   ST_*             status register bit indices
//   CTRL_*           ctrl register field positions
//   sel_e            decoded access target
//   decode_addr()    maps a word address to its target
package mem_map_pkg;

   localparam logic [15:0] IO_BASE = 16'hFF00;

   localparam logic [7:0] OFF_LED    = 8'd0;
   localparam logic [7:0] OFF_TCOUNT = 8'd1;
   localparam logic [7:0] OFF_TCOMP  = 8'd2;
   localparam logic [7:0] OFF_STATUS = 8'd3;
   localparam logic [7:0] OFF_CTRL   = 8'd4;

   localparam int ST_MATCH    = 0;
   localparam int ST_UNMAPPED = 1;
   localparam int ST_COLLIDE  = 2;
   localparam int ST_BITS     = 3;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_MASK_LSB  = 4;
   localparam int CTRL_MASK_BITS = 3;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_LED,
      SEL_TCOUNT,
      SEL_TCOMP,
      SEL_STATUS,
      SEL_CTRL
   } sel_e;

   // RAM takes priority; anything that is neither RAM nor one of the five
   // I/O registers is unmapped (SEL_NONE).
   function automatic sel_e decode_addr(input logic [15:0] addr,
                                        input int unsigned addr_bits,
                                        input logic [15:0] io_base);
      logic [15:0] off;
      sel_e        sel;
      off = addr - io_base;
      sel = SEL_NONE;
      if ((32'(addr) >> addr_bits) == 32'd0) begin
         sel = SEL_RAM;
      end else begin
         case (off)
            {8'h00, OFF_LED}:    sel = SEL_LED;
            {8'h00, OFF_TCOUNT}: sel = SEL_TCOUNT;
            {8'h00, OFF_TCOMP}:  sel = SEL_TCOMP;
            {8'h00, OFF_STATUS}: sel = SEL_STATUS;
            {8'h00, OFF_CTRL}:   sel = SEL_CTRL;
            default:             sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/io_timer.sv
// rtl/io_timer.sv - prescaled 16-bit timer with compare register
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   enable              prescaler and count advance only while high
//   count_load          load count from load_data (wins over increment)
//   compare_load        load compare from load_data
//   load_data[15:0]     CPU write data
//   count[15:0]         current count
//   compare[15:0]       current compare value
//   tick                one-cycle pulse when the prescaler wraps
//   match               tick whose incremented count equals compare
module io_timer #(
   parameter int PRESCALE = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        count_load,
   input  logic        compare_load,
   input  logic [15:0] load_data,
   output logic [15:0] count,
   output logic [15:0] compare,
   output logic        tick,
   output logic        match
);

   localparam int          PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] presc;
   logic [15:0]   count_inc;

   assign tick      = enable && (presc == PMAX);
   assign count_inc = count + 16'd1;
   // A count load in the tick cycle replaces the increment, so no match then.
   assign match     = tick && !count_load && (count_inc == compare);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc   <= '0;
         count   <= '0;
         compare <= 16'hFFFF;
      end else begin
         if (enable) begin
            presc <= (presc == PMAX) ? '0 : presc + PW'(1);
         end
         if (count_load) begin
            count <= load_data;
         end else if (tick) begin
            count <= count_inc;
         end
         if (compare_load) begin
            compare <= load_data;
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - zero-wait-state RAM plus memory-mapped I/O page for the CPU
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mem_address[15:0]         word address from CPU
//   mem_write_data[15:0]      write data from CPU
//   mem_read_data[15:0]       combinational read data, 0 when not reading
//   mem_read_en               read request (one cycle per access)
//   mem_write_en              write request (one cycle per access)
//   led_out[7:0]              LED register
//   irq                       registered OR of (status & irq mask)
module mem_responder #(
   parameter int          ADDR_BITS = 12,
   parameter int          PRESCALE  = 16,
   parameter logic [15:0] IO_BASE   = mem_map_pkg::IO_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_write_data,
   output logic [15:0] mem_read_data,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   output logic [7:0]  led_out,
   output logic        irq
);

   import mem_map_pkg::*;

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [15:0]          ram [DEPTH];
   logic [ADDR_BITS-1:0] ram_idx;

   sel_e        sel;
   logic        access;
   logic        collide;

   logic [7:0]                led;
   logic                      ctrl_en;
   logic [CTRL_MASK_BITS-1:0] irq_mask;
   logic [ST_BITS-1:0]        status;
   logic [ST_BITS-1:0]        status_set;
   logic [ST_BITS-1:0]        status_clr;
   logic [ST_BITS-1:0]        status_next;
   logic [15:0]               ctrl_word;

   logic [15:0] timer_count;
   logic [15:0] timer_compare;
   logic        timer_tick;
   logic        timer_match;

   assign sel     = decode_addr(mem_address, ADDR_BITS, IO_BASE);
   assign ram_idx = mem_address[ADDR_BITS-1:0];
   assign access  = mem_read_en || mem_write_en;
   assign collide = mem_read_en && mem_write_en;

   assign led_out   = led;
   assign ctrl_word = 16'(ctrl_en) | (16'(irq_mask) << CTRL_MASK_LSB);

   io_timer #(
      .PRESCALE(PRESCALE)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .enable      (ctrl_en),
      .count_load  (mem_write_en && (sel == SEL_TCOUNT)),
      .compare_load(mem_write_en && (sel == SEL_TCOMP)),
      .load_data   (mem_write_data),
      .count       (timer_count),
      .compare     (timer_compare),
      .tick        (timer_tick),
      .match       (timer_match)
   );

   // Set has priority over a same-cycle write-1-to-clear.
   always_comb begin
      status_set              = '0;
      status_set[ST_MATCH]    = timer_match;
      status_set[ST_UNMAPPED] = access && (sel == SEL_NONE);
      status_set[ST_COLLIDE]  = collide;
      status_clr              = '0;
      if (mem_write_en && (sel == SEL_STATUS)) begin
         status_clr = mem_write_data[ST_BITS-1:0];
      end
      status_next = (status & ~status_clr) | status_set;
   end

   // A collision performs the write but returns 0 to the reader.
   always_comb begin
      mem_read_data = '0;
      if (mem_read_en && !mem_write_en) begin
         case (sel)
            SEL_RAM:    mem_read_data = ram[ram_idx];
            SEL_LED:    mem_read_data = {8'h00, led};
            SEL_TCOUNT: mem_read_data = timer_count;
            SEL_TCOMP:  mem_read_data = timer_compare;
            SEL_STATUS: mem_read_data = {{(16 - ST_BITS){1'b0}}, status};
            SEL_CTRL:   mem_read_data = ctrl_word;
            default:    mem_read_data = '0;
         endcase
      end
   end

   // RAM has no reset; gating on rst drops a write that coincides with reset.
   always_ff @(posedge clk) begin
      if (rst && mem_write_en && (sel == SEL_RAM)) begin
         ram[ram_idx] <= mem_write_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led      <= '0;
         ctrl_en  <= 1'b0;
         irq_mask <= '0;
         status   <= '0;
         irq      <= 1'b0;
      end else begin
         if (mem_write_en && (sel == SEL_LED)) begin
            led <= mem_write_data[7:0];
         end
         if (mem_write_en && (sel == SEL_CTRL)) begin
            ctrl_en  <= mem_write_data[CTRL_EN];
            irq_mask <= mem_write_data[CTRL_MASK_LSB +: CTRL_MASK_BITS];
         end
         status <= status_next;
         // irq follows the status register by one cycle.
         irq    <= |(status & irq_mask);
      end
   end

   logic unused_tick;
   assign unused_tick = timer_tick;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder with a behavioural model
module tb_mem_responder;

   localparam int P = 4;

   logic        clk;
   logic        rst;
   logic [15:0] mem_address;
   logic [15:0] mem_write_data;
   logic [15:0] mem_read_data;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [7:0]  led_out;
   logic        irq;

   int n_tests;
   int n_fail;

   mem_responder #(
      .ADDR_BITS(12),
      .PRESCALE (P),
      .IO_BASE  (16'hFF00)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data),
      .mem_read_en   (mem_read_en),
      .mem_write_en  (mem_write_en),
      .led_out       (led_out),
      .irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   logic [15:0] m_ram [0:4095];
   logic [7:0]  m_led;
   logic [15:0] m_count;
   logic [15:0] m_comp;
   logic [15:0] m_ctrl;
   logic [2:0]  m_status;
   logic        m_irq;
   int          m_phase;

   task automatic model_reset();
      m_led    = 8'h00;
      m_count  = 16'h0000;
      m_comp   = 16'hFFFF;
      m_ctrl   = 16'h0000;
      m_status = 3'b000;
      m_irq    = 1'b0;
      m_phase  = 0;
   endtask

   function automatic logic is_unmapped(input logic [15:0] a);
      return !(a < 16'h1000) && !(a >= 16'hFF00 && a <= 16'hFF04);
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      if (a < 16'h1000)  return m_ram[a[11:0]];
      if (a == 16'hFF00) return {8'h00, m_led};
      if (a == 16'hFF01) return m_count;
      if (a == 16'hFF02) return m_comp;
      if (a == 16'hFF03) return {13'h0, m_status};
      if (a == 16'hFF04) return m_ctrl;
      return 16'h0000;
   endfunction

   task automatic model_step(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d);
      logic        tick;
      logic        load;
      logic [15:0] nc;
      logic [2:0]  set;
      logic [2:0]  clr;
      m_irq = |(m_status & m_ctrl[6:4]);
      tick  = m_ctrl[0] && (m_phase == P - 1);
      load  = we && (a == 16'hFF01);
      set   = 3'b000;
      nc    = tick ? m_count + 16'd1 : m_count;
      if (tick && !load && nc == m_comp) set[0] = 1'b1;
      if (load) nc = d;
      if ((re || we) && is_unmapped(a)) set[1] = 1'b1;
      if (re && we) set[2] = 1'b1;
      clr = (we && a == 16'hFF03) ? d[2:0] : 3'b000;
      if (m_ctrl[0]) m_phase = (m_phase + 1) % P;
      m_count = nc;
      if (we) begin
         if (a < 16'h1000)  m_ram[a[11:0]] = d;
         if (a == 16'hFF00) m_led = d[7:0];
         if (a == 16'hFF02) m_comp = d;
         if (a == 16'hFF04) m_ctrl = d & 16'h0071;
      end
      m_status = (m_status & ~clr) | set;
   endtask

   // One bus cycle: drive at posedge+1, sample read data before the next edge,
   // advance the model at that edge, return at posedge+1.
   task automatic bus(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic [15:0] exp_rd);
      mem_read_en    = re;
      mem_write_en   = we;
      mem_address    = a;
      mem_write_data = d;
      #3;
      rd     = mem_read_data;
      exp_rd = (re && !we) ? model_read(a) : 16'h0000;
      @(posedge clk);
      model_step(re, we, a, d);
      #1;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] rd, er;
      rst = 1'b0;
      mem_read_en = 1'b0; mem_write_en = 1'b0;
      mem_address = 16'h0; mem_write_data = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      n_tests++;
      if (led_out !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", led_out); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
      bus(1, 0, 16'hFF03, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_status got %h want 0000", rd); end
      bus(1, 0, 16'hFF02, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL reset_compare got %h want FFFF", rd); end
      bus(1, 0, 16'hFF00, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_led_rd got %h want 0000", rd); end
   endtask

   task automatic test_ram();
      logic [15:0] rd, er;
      bus(0, 1, 16'h0000, 16'h1111, rd, er);
      bus(0, 1, 16'h0100, 16'h1234, rd, er);
      bus(1, 0, 16'h0100, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h1234) begin n_fail++; $display("FAIL ram_0100 got %h want 1234", rd); end
      bus(0, 1, 16'h0FFF, 16'hABCD, rd, er);
      bus(1, 0, 16'h0FFF, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'hABCD) begin n_fail++; $display("FAIL ram_0fff got %h want ABCD", rd); end
      bus(0, 0, 16'h0100, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL ram_no_re got %h want 0000", rd); end
   endtask

   task automatic test_timer();
      logic [15:0] rd, er;
      bus(0, 1, 16'hFF02, 16'd3, rd, er);
      bus(0, 1, 16'hFF04, 16'h0011, rd, er);
      for (int k = 0; k < 11; k++) bus(0, 0, 16'h0, 16'h0, rd, er);
      bus(1, 0, 16'hFF03, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL timer_early got %h want 0000", rd); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_lag got %b want 0", irq); end
      bus(1, 0, 16'hFF03, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0001) begin n_fail++; $display("FAIL timer_match got %h want 0001", rd); end
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_irq got %b want 1", irq); end
      bus(0, 1, 16'hFF03, 16'h0001, rd, er);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_irq_hold got %b want 1", irq); end
      bus(1, 0, 16'hFF03, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL timer_clear got %h want 0000", rd); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_drop got %b want 0", irq); end
      bus(1, 0, 16'hFF01, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'd3) begin n_fail++; $display("FAIL timer_count got %h want 0003", rd); end
      bus(0, 1, 16'hFF04, 16'h0000, rd, er);
      bus(0, 1, 16'hFF03, 16'h0007, rd, er);
   endtask

   task automatic test_unmapped();
      logic [15:0] rd, er;
      bus(0, 1, 16'h2000, 16'h5555, rd, er);
      bus(1, 0, 16'h2000, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL unmapped_rd got %h want 0000", rd); end
      bus(1, 0, 16'hFF03, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0002) begin n_fail++; $display("FAIL unmapped_status got %h want 0002", rd); end
      bus(1, 0, 16'h0000, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h1111) begin n_fail++; $display("FAIL unmapped_ram0 got %h want 1111", rd); end
      bus(1, 0, 16'hFF05, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL io_plus5 got %h want 0000", rd); end
      bus(0, 1, 16'hFF03, 16'h0007, rd, er);
   endtask

   task automatic test_collision();
      logic [15:0] rd, er;
      bus(1, 1, 16'h0200, 16'h00FF, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL collide_rd got %h want 0000", rd); end
      bus(1, 0, 16'h0200, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h00FF) begin n_fail++; $display("FAIL collide_write got %h want 00FF", rd); end
      bus(1, 0, 16'hFF03, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0004) begin n_fail++; $display("FAIL collide_status got %h want 0004", rd); end
      bus(0, 1, 16'hFF03, 16'h0007, rd, er);
   endtask

   task automatic test_random();
      logic [15:0] rd, er, a, d;
      logic        re, we;
      int          k, r;
      for (int i = 0; i < 16; i++) bus(0, 1, 16'(i * 257), 16'($urandom), rd, er);
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 9);
         if (k < 5)       a = 16'($urandom_range(0, 15) * 257);
         else if (k < 8)  a = 16'hFF00 + 16'($urandom_range(0, 4));
         else if (k == 8) a = 16'hFF05 + 16'($urandom_range(0, 250));
         else             a = 16'h1000 + 16'($urandom_range(0, 16'hEEFF));
         r  = $urandom_range(0, 7);
         re = (r <= 2) || (r == 6);
         we = (r >= 3 && r <= 6);
         d  = 16'($urandom);
         bus(re, we, a, d, rd, er);
         n_tests++;
         if (rd !== er) begin n_fail++; $display("FAIL rand_rd[%0d] a=%h got %h want %h", i, a, rd, er); end
         n_tests++;
         if (led_out !== m_led) begin n_fail++; $display("FAIL rand_led[%0d] got %h want %h", i, led_out, m_led); end
         n_tests++;
         if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq[%0d] got %b want %b", i, irq, m_irq); end
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] rd, er;
      bus(0, 1, 16'hFF00, 16'h0055, rd, er);
      n_tests++;
      if (led_out !== 8'h55) begin n_fail++; $display("FAIL mid_led_pre got %h want 55", led_out); end
      mem_read_en = 1'b0; mem_write_en = 1'b1;
      mem_address = 16'hFF00; mem_write_data = 16'h00AA;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (led_out !== 8'h00) begin n_fail++; $display("FAIL mid_led_async got %h want 00", led_out); end
      @(posedge clk);
      #1;
      n_tests++;
      if (led_out !== 8'h00) begin n_fail++; $display("FAIL mid_led_held got %h want 00", led_out); end
      mem_write_en = 1'b0;
      rst = 1'b1;
      bus(0, 0, 16'h0, 16'h0, rd, er);
      n_tests++;
      if (led_out !== 8'h00) begin n_fail++; $display("FAIL mid_led_release got %h want 00", led_out); end
      bus(1, 0, 16'hFF03, 16'h0, rd, er);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL mid_status got %h want 0000", rd); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq got %b want 0", irq); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_ram();
      test_timer();
      test_unmapped();
      test_collision();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
